uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OSR, default 16, oversampling ticks per bit (fixed at 16 in this release).
REQ-002 SHALL have port rx_clk  input  1  sole clock, 16x baud (rx_clk from clk_gen).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  serial line, idle high, asynchronous to rx_clk.
REQ-005 SHALL have port length  input  4  data bits per frame (5..8).
REQ-006 SHALL have port parity_en  input  1  parity bit present.
REQ-007 SHALL have port parity_type  input  1  1 = even parity (bit = ^data), 0 = odd parity (bit = ~^data).
REQ-008 SHALL have port stop2  input  1  two stop bits expected.
REQ-009 SHALL have port rx_data  output  8  received word, LSB-aligned, unused MSBs zero.
REQ-010 SHALL have port rx_done  output  1  one-cycle pulse, frame complete.
REQ-011 SHALL have port parity_err  output  1  parity mismatch on last frame.
REQ-012 SHALL have port frame_err  output  1  a stop bit sampled low on last frame.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value (2-cycle latency).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
REQ-015 IDLE: on a synchronized falling edge (1 then 0), SHALL clear the tick counter, latch length/parity_en/parity_type/stop2, and enter START.
REQ-016 SHALL treat length values outside 5..8 as 8.
REQ-017 SHALL sample each bit at tick 7 (mid-bit) of a 0..15 tick counter; the counter wraps 15->0 at each bit boundary.
REQ-018 START: a sample of 1 at tick 7 SHALL be a false start -> IDLE, with no output change; a sample of 0 -> DATA after tick 15.
REQ-019 DATA: SHALL shift bits in LSB first, advance after tick 15 of bit length-1, then go to PARITY if parity_en, else STOP1.
REQ-020 PARITY: SHALL compare the sample against the parity computed over the received bits per parity_type; mismatch sets the pending parity error.
REQ-021 STOP1/STOP2: a low sample SHALL set the pending frame error; STOP1 -> STOP2 if stop2, else DONE; transition occurs at tick 7 sample (no wait for bit end).
REQ-022 DONE: for exactly one cycle, SHALL update rx_data/parity_err/frame_err and pulse rx_done, then return to IDLE.
REQ-023 Outputs rx_data, parity_err, frame_err SHALL hold until the next DONE.
REQ-024 Config input changes mid-frame SHALL have no effect on the frame in progress.
REQ-025 A falling edge arriving in the first cycle after DONE SHALL be detected (back-to-back frames, no lost start).
REQ-026 With frame_err set, the received data SHALL still be reported.

Reset
REQ-027 On rst low, SHALL immediately set state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_done 0, parity_err 0, frame_err 0.
REQ-028 A reset asserted mid-frame SHALL discard the partial frame; after release, a frame is accepted only from a new falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state enum, OSR=16, SAMPLE_TICK=7 and the parity_type encoding shared with uart_tx.
REQ-030 SHALL be a single module with no sub-modules; the synchronizer is inline.

Verification
REQ-031 8N1, 0xA5 sent LSB first -> one rx_done pulse, rx_data=0xA5, both error flags 0.
REQ-032 7-bit even parity, data 0x35, parity bit 0 -> rx_data=0x35, parity_err=0; the same frame with parity bit 1 -> parity_err=1.
REQ-033 8N2, 0x3C with the second stop bit low -> rx_data=0x3C, frame_err=1.
REQ-034 rx low for 4 ticks, then high -> no rx_done, state back to IDLE, outputs unchanged.
REQ-035 rst low during bit 3 of a frame, released, then 5N1 frame 0x1F -> exactly one rx_done, rx_data=0x1F.
REQ-036 Two back-to-back 8N1 frames 0x00 then 0xFF, no idle gap -> two rx_done pulses, 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity_type encoding used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned UART_OSR    = 16;
  localparam logic [3:0]  SAMPLE_TICK = 4'd7;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_DONE
  } rx_state_e;

  // Frame lengths outside 5..8 fall back to 8 data bits.
  function automatic logic [3:0] norm_len(input logic [3:0] len);
    return (len >= 4'd5 && len <= 4'd8) ? len : 4'd8;
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic ptype);
    return (ptype == PARITY_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional parity, one or two
// stop bits. rx is synchronized inline; results are reported with a done pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OSR = UART_OSR
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] length,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [3:0] LAST_TICK = 4'(OSR - 1);

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] len_q, len_d;
  logic       par_en_q, par_en_d;
  logic       par_type_q, par_type_d;
  logic       stop2_q, stop2_d;
  logic       perr_pend_q, perr_pend_d;
  logic       ferr_pend_q, ferr_pend_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_done_q, rx_done_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;

  logic sample, bit_end, fall;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign sample  = (tick_q == SAMPLE_TICK);
  assign bit_end = (tick_q == LAST_TICK);
  assign fall    = rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d      = state_q;
    tick_d       = bit_end ? '0 : tick_q + 4'd1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    stop2_d      = stop2_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        if (fall) begin
          state_d     = RX_START;
          bit_d       = '0;
          shift_d     = '0;
          len_d       = norm_len(length);
          par_en_d    = parity_en;
          par_type_d  = parity_type;
          stop2_d     = stop2;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      RX_START: begin
        if (sample && rx_sync_q) state_d = RX_IDLE;
        else if (bit_end)        state_d = RX_DATA;
      end
      RX_DATA: begin
        if (sample) shift_d[bit_q] = rx_sync_q;
        if (bit_end) begin
          if ({1'b0, bit_q} == len_q - 4'd1) state_d = par_en_q ? RX_PARITY : RX_STOP1;
          else                                bit_d   = bit_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (sample && (rx_sync_q != parity_bit(shift_q, par_type_q))) perr_pend_d = 1'b1;
        if (bit_end) state_d = RX_STOP1;
      end
      // Stop bits move on at the mid-bit sample so a back-to-back start edge
      // is seen while already back in IDLE.
      RX_STOP1: begin
        if (sample) begin
          if (!rx_sync_q) ferr_pend_d = 1'b1;
          state_d = stop2_q ? RX_STOP2 : RX_DONE;
        end
      end
      RX_STOP2: begin
        if (sample) begin
          if (!rx_sync_q) ferr_pend_d = 1'b1;
          state_d = RX_DONE;
        end
      end
      RX_DONE: begin
        tick_d       = '0;
        rx_data_d    = shift_q;
        parity_err_d = perr_pend_q;
        frame_err_d  = ferr_pend_q;
        rx_done_d    = 1'b1;
        state_d      = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      len_q        <= 4'd8;
      par_en_q     <= 1'b0;
      par_type_q   <= PARITY_EVEN;
      stop2_q      <= 1'b0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      stop2_q      <= stop2_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences; expected results queue up as frames are driven.
module tb_uart_rx;
  import uart_pkg::*;

  logic       rx_clk;
  logic       rst;
  logic       rx;
  logic [3:0] length;
  logic       parity_en;
  logic       parity_type;
  logic       stop2;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;

  uart_rx #(.OSR(16)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx          (rx),
    .length      (length),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [3:0] len;
    logic       pen;
    logic       ptype;
    logic       st2;
    logic [7:0] data;
    logic       pflip;
    logic [1:0] sbad;
    logic [7:0] edata;
    logic       eperr;
    logic       eferr;
  } vec_t;

  exp_t  exp_q[$];
  vec_t  vecs[11];
  int    errors = 0;
  int    checks = 0;
  int    done_count = 0;
  logic  prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic b, input int unsigned n);
    rx = b;
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [3:0] len, input logic pen, input logic ptype,
                            input logic st2, input logic [7:0] data, input logic pflip,
                            input logic [1:0] sbad, input logic midchange);
    int unsigned eff;
    logic [7:0]  m;
    logic        pb;
    length      = len;
    parity_en   = pen;
    parity_type = ptype;
    stop2       = st2;
    eff = (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
    m = '0;
    for (int unsigned i = 0; i < eff; i++) m[i] = data[i];
    drive_bit(1'b0, 16);
    if (midchange) begin
      length      = 4'd5;
      parity_en   = ~pen;
      parity_type = ~ptype;
      stop2       = ~st2;
    end
    for (int unsigned i = 0; i < eff; i++) drive_bit(m[i], 16);
    if (pen) begin
      pb = (ptype == PARITY_EVEN) ? ^m : ~^m;
      drive_bit(pb ^ pflip, 16);
    end
    drive_bit(~sbad[0], 16);
    if (st2) drive_bit(~sbad[1], 16);
    rx          = 1'b1;
    length      = len;
    parity_en   = pen;
    parity_type = ptype;
    stop2       = st2;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge rx_clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   base;

    rst = 1'b0; rx = 1'b1; length = 4'd8;
    parity_en = 1'b0; parity_type = PARITY_EVEN; stop2 = 1'b0;

    fork
      forever begin
        @(negedge rx_clk);
        if (rx_done) begin
          done_count++;
          check("done_pulse_width", prev_done, 1'b0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got rx_done=1 with data 0x%0h, required no pulse", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", rx_data, e.data);
            check("parity_err", parity_err, e.perr);
            check("frame_err", frame_err, e.ferr);
          end
        end
        prev_done = rx_done;
      end
    join_none

    repeat (3) @(negedge rx_clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    @(posedge rx_clk); #1;
    rst = 1'b1;
    drive_bit(1'b1, 20);

    //        len    pen   ptype st2   data   pflip sbad   edata  eperr eferr
    vecs[0]  = '{4'd8, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{4'd7, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 2'b00, 8'h35, 1'b0, 1'b0};
    vecs[2]  = '{4'd7, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 2'b00, 8'h35, 1'b1, 1'b0};
    vecs[3]  = '{4'd8, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1};
    vecs[4]  = '{4'd5, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0};
    vecs[5]  = '{4'd8, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b0, 2'b00, 8'h0F, 1'b0, 1'b0};
    vecs[6]  = '{4'd6, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 2'b00, 8'h3F, 1'b0, 1'b0};
    vecs[7]  = '{4'd3, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 2'b00, 8'h81, 1'b0, 1'b0};
    vecs[8]  = '{4'd0, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0, 2'b00, 8'h7E, 1'b0, 1'b0};
    vecs[9]  = '{4'd8, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    vecs[10] = '{4'd8, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < 11; i++) begin
      e.data = vecs[i].edata; e.perr = vecs[i].eperr; e.ferr = vecs[i].eferr;
      exp_q.push_back(e);
      send_frame(vecs[i].len, vecs[i].pen, vecs[i].ptype, vecs[i].st2,
                 vecs[i].data, vecs[i].pflip, vecs[i].sbad, 1'b0);
      drive_bit(1'b1, 20);
      drain($sformatf("drain_vec%0d", i));
    end

    // False start: 4 ticks low then high; nothing reported, outputs held.
    base = done_count;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 200);
    check("false_start_no_done", done_count - base, 0);
    check("false_start_rx_data", rx_data, 8'h00);
    check("false_start_parity_err", parity_err, 1'b1);
    check("false_start_frame_err", frame_err, 1'b1);

    // Reset in the middle of bit 3, then a fresh 5N1 frame.
    length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 48);
    drive_bit(1'b0, 8);
    rst = 1'b0;
    #1;
    check("midreset_frame_err", frame_err, 1'b0);
    check("midreset_parity_err", parity_err, 1'b0);
    rx = 1'b1;
    drive_bit(1'b1, 4);
    rst = 1'b1;
    drive_bit(1'b1, 40);
    base = done_count;
    e.data = 8'h1F; e.perr = 1'b0; e.ferr = 1'b0;
    exp_q.push_back(e);
    send_frame(4'd5, 1'b0, PARITY_EVEN, 1'b0, 8'h1F, 1'b0, 2'b00, 1'b0);
    drive_bit(1'b1, 40);
    drain("drain_after_reset");
    check("after_reset_done_count", done_count - base, 1);

    // Config inputs change right after the start bit; the latched config rules.
    e.data = 8'hC3; e.perr = 1'b0; e.ferr = 1'b0;
    exp_q.push_back(e);
    send_frame(4'd8, 1'b0, PARITY_EVEN, 1'b0, 8'hC3, 1'b0, 2'b00, 1'b1);
    drive_bit(1'b1, 40);
    drain("drain_midchange");

    // Back-to-back frames with no idle gap.
    base = done_count;
    e.data = 8'h00; exp_q.push_back(e);
    e.data = 8'hFF; exp_q.push_back(e);
    send_frame(4'd8, 1'b0, PARITY_EVEN, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
    send_frame(4'd8, 1'b0, PARITY_EVEN, 1'b0, 8'hFF, 1'b0, 2'b00, 1'b0);
    drive_bit(1'b1, 40);
    drain("drain_back_to_back");
    check("back_to_back_done_count", done_count - base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
